// File: rtl/sie_pkg.sv
// sie_pkg: shared SIE transmit/receive constants (word width, idle line level)
package sie_pkg;
  localparam int DATA_W = 8;
  localparam logic IDLE_BIT = 1'b0;
endpackage

// File: rtl/piso_block.sv
// piso_block: byte PISO, LOAD captures Parallel_ip, Serial_op shifts out one bit per CLOCK (RST async active-low)
module piso_block #(
  parameter int DATA_W = sie_pkg::DATA_W,
  parameter int LSB_FIRST = 1,
  parameter logic IDLE_BIT = sie_pkg::IDLE_BIT
) (
  input  logic [DATA_W-1:0] Parallel_ip,
  input  logic              CLOCK,
  input  logic              LOAD,
  input  logic              RST,
  output logic              Serial_op
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic [DATA_W-1:0] sreg_q, sreg_d, load_rem, shift_rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_q, out_d, load_first, next_bit;
  assign load_first = LSB_FIRST != 0 ? Parallel_ip[0] : Parallel_ip[DATA_W-1];
  assign load_rem   = LSB_FIRST != 0 ? {IDLE_BIT, Parallel_ip[DATA_W-1:1]} : {Parallel_ip[DATA_W-2:0], IDLE_BIT};
  assign next_bit   = LSB_FIRST != 0 ? sreg_q[0] : sreg_q[DATA_W-1];
  assign shift_rem  = LSB_FIRST != 0 ? {IDLE_BIT, sreg_q[DATA_W-1:1]} : {sreg_q[DATA_W-2:0], IDLE_BIT};
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    out_d  = IDLE_BIT;
    if (LOAD) begin
      out_d  = load_first;
      sreg_d = load_rem;
      cnt_d  = CW'(DATA_W - 1);
    end else if (cnt_q != '0) begin
      out_d  = next_bit;
      sreg_d = shift_rem;
      cnt_d  = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      out_q  <= IDLE_BIT;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end
  assign Serial_op = out_q;
endmodule

// File: tb/tb_piso_block.sv
// tb_piso_block: scoreboard bench for LSB-first and MSB-first piso_block instances
module tb_piso_block;
  logic clk = 1'b0, rst_n = 1'b1, load = 1'b0;
  logic [7:0] pdata = '0;
  logic so_l, so_m, gl, gm, el, em;
  logic exp_l[$], exp_m[$];
  int n_cmp = 0, n_err = 0;
  always #10 clk = ~clk;
  piso_block u_lsb (.Parallel_ip(pdata), .CLOCK(clk), .LOAD(load), .RST(rst_n), .Serial_op(so_l));
  piso_block #(.LSB_FIRST(0)) u_msb (.Parallel_ip(pdata), .CLOCK(clk), .LOAD(load), .RST(rst_n), .Serial_op(so_m));
  task automatic step(input logic ld, input logic [7:0] d);
    load = ld;
    pdata = d;
    if (ld) begin
      exp_l.delete();
      exp_m.delete();
      for (int i = 0; i < 8; i++) begin
        exp_l.push_back(d[i]);
        exp_m.push_back(d[7-i]);
      end
    end
    @(posedge clk);
    #1;
    gl = so_l;
    gm = so_m;
    el = exp_l.size() != 0 ? exp_l.pop_front() : 1'b0;
    em = exp_m.size() != 0 ? exp_m.pop_front() : 1'b0;
  endtask
  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    load = 1'b1;
    pdata = 8'h8B;
    #1;
    n_cmp += 2;
    if (so_l !== 1'b0) begin n_err++; $display("FAIL reset_async_lsb got=%b want=0", so_l); end
    if (so_m !== 1'b0) begin n_err++; $display("FAIL reset_async_msb got=%b want=0", so_m); end
    @(posedge clk);
    #1;
    n_cmp += 2;
    if (so_l !== 1'b0) begin n_err++; $display("FAIL reset_hold_lsb got=%b want=0", so_l); end
    if (so_m !== 1'b0) begin n_err++; $display("FAIL reset_hold_msb got=%b want=0", so_m); end
    #4;
    rst_n = 1'b1;
  endtask
  task automatic test_single_word();
    for (int k = 0; k < 10; k++) begin
      step(k == 0, k == 0 ? 8'h8B : 8'($urandom));
      n_cmp += 2;
      if (gl !== el) begin n_err++; $display("FAIL single_lsb[%0d] got=%b want=%b", k, gl, el); end
      if (gm !== em) begin n_err++; $display("FAIL single_msb[%0d] got=%b want=%b", k, gm, em); end
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 18; k++) begin
      step(k == 0 || k == 8, k == 0 ? 8'h8B : k == 8 ? 8'hAA : 8'($urandom));
      n_cmp += 2;
      if (gl !== el) begin n_err++; $display("FAIL b2b_lsb[%0d] got=%b want=%b", k, gl, el); end
      if (gm !== em) begin n_err++; $display("FAIL b2b_msb[%0d] got=%b want=%b", k, gm, em); end
    end
  endtask
  task automatic test_abort();
    for (int k = 0; k < 12; k++) begin
      step(k == 0 || k == 3, k == 0 ? 8'hFF : k == 3 ? 8'h00 : 8'($urandom));
      n_cmp += 2;
      if (gl !== el) begin n_err++; $display("FAIL abort_lsb[%0d] got=%b want=%b", k, gl, el); end
      if (gm !== em) begin n_err++; $display("FAIL abort_msb[%0d] got=%b want=%b", k, gm, em); end
      if (k == 3) begin
        n_cmp++;
        if (u_lsb.cnt_q !== 4'd7) begin n_err++; $display("FAIL abort_cnt got=%0d want=7", u_lsb.cnt_q); end
      end
    end
  endtask
  task automatic test_reset_mid_word();
    for (int k = 0; k < 4; k++) begin
      step(k == 0, k == 0 ? 8'hFF : 8'($urandom));
      n_cmp += 2;
      if (gl !== el) begin n_err++; $display("FAIL midrst_pre_lsb[%0d] got=%b want=%b", k, gl, el); end
      if (gm !== em) begin n_err++; $display("FAIL midrst_pre_msb[%0d] got=%b want=%b", k, gm, em); end
    end
    #2;
    rst_n = 1'b0;
    exp_l.delete();
    exp_m.delete();
    #1;
    n_cmp += 2;
    if (so_l !== 1'b0) begin n_err++; $display("FAIL midrst_async_lsb got=%b want=0", so_l); end
    if (so_m !== 1'b0) begin n_err++; $display("FAIL midrst_async_msb got=%b want=0", so_m); end
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'($urandom));
      n_cmp += 2;
      if (gl !== el) begin n_err++; $display("FAIL midrst_post_lsb[%0d] got=%b want=%b", k, gl, el); end
      if (gm !== em) begin n_err++; $display("FAIL midrst_post_msb[%0d] got=%b want=%b", k, gm, em); end
    end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
